// File: rtl/ram_block_mover_pkg.sv
// Shared definitions for the RAM block mover: default bus geometry
// (shared with the data RAM), the operation mode constants and the FSM
// state encoding.
package ram_block_mover_pkg;

  localparam int DEF_AW    = 6;
  localparam int DEF_DW    = 16;
  localparam int DEF_DEPTH = 10;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CHK  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/ram_mover_addr_gen.sv
// Address generator for the block mover: loadable up/down source and
// destination pointers plus the words-written counter, with a flag that
// says the word being written now is the last one of the block.
module ram_mover_addr_gen
  import ram_block_mover_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          desc_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  input  logic [AW:0]   len_i,
  output logic [AW-1:0] src_ptr_o,
  output logic [AW-1:0] dst_ptr_o,
  output logic [AW:0]   count_o,
  output logic          last_o
);

  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] span_s;
  logic [AW:0]   count_inc_s;

  // Offset of the last word of the block; only used when len is legal
  // and non-zero, so the low AW bits of len are sufficient.
  assign span_s      = len_i[AW-1:0] - PTR_ONE;
  assign count_inc_s = count_q + CNT_ONE;
  assign last_o      = (count_inc_s == len_i);

  assign src_ptr_o = src_ptr_q;
  assign dst_ptr_o = dst_ptr_q;
  assign count_o   = count_q;

  // Next-state for pointers and counter: clear on accept, load at check, step per write.
  always_comb begin
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      if (desc_i) begin
        src_ptr_d = src_base_i + span_s;
        dst_ptr_d = dst_base_i + span_s;
      end else begin
        src_ptr_d = src_base_i;
        dst_ptr_d = dst_base_i;
      end
    end else if (step_i) begin
      count_d = count_inc_s;
      if (desc_i) begin
        src_ptr_d = src_ptr_q - PTR_ONE;
        dst_ptr_d = dst_ptr_q - PTR_ONE;
      end else begin
        src_ptr_d = src_ptr_q + PTR_ONE;
        dst_ptr_d = dst_ptr_q + PTR_ONE;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: rtl/ram_block_mover.sv
// Block COPY (memmove semantics) / FILL master for the single-port data
// RAM. A request is latched in IDLE, range-checked in CHK, then moved one
// word per RD/WR pair (COPY) or one word per WR cycle (FILL).
module ram_block_mover
  import ram_block_mover_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW:0]   count,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW:0]   len_q, len_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          err_q, err_d;

  logic [AW+1:0] src_end_s, dst_end_s;
  logic          range_err_s, desc_s, last_s;
  logic [AW-1:0] src_ptr_s, dst_ptr_s;

  // End addresses one bit wider than len so an oversized block cannot wrap.
  assign src_end_s   = {2'b00, src_q} + {1'b0, len_q};
  assign dst_end_s   = {2'b00, dst_q} + {1'b0, len_q};
  assign range_err_s = (dst_end_s > DEPTH_W) ||
                       ((mode_q == MODE_COPY) && (src_end_s > DEPTH_W));
  // Copy top-down when the destination lies above the source so an
  // overlapping source word is read before it is overwritten.
  assign desc_s      = (mode_q == MODE_COPY) && (dst_q > src_q);

  ram_mover_addr_gen #(.AW(AW)) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear_i    ((state_q == ST_IDLE) && start),
    .load_i     (state_q == ST_CHK),
    .step_i     (state_q == ST_WR),
    .desc_i     (desc_s),
    .src_base_i (src_q),
    .dst_base_i (dst_q),
    .len_i      (len_q),
    .src_ptr_o  (src_ptr_s),
    .dst_ptr_o  (dst_ptr_s),
    .count_o    (count),
    .last_o     (last_s)
  );

  // FSM next-state and request/hold register updates.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          fill_d  = fill_val;
          err_d   = 1'b0;
          state_d = ST_CHK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (range_err_s) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (len_q == '0) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        hold_d  = ram_do;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (last_s) begin
          state_d = ST_DONE;
        end else if (mode_q == MODE_COPY) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q == ST_RD) || (state_q == ST_WR);
  assign done = (state_q == ST_DONE);
  assign err  = err_q;
  // Reset masks the write strobe so the RAM sees no write at the very
  // edge where reset is sampled.
  assign ram_we = (state_q == ST_WR) && !rst;

  // RAM address/data decode from the current state.
  always_comb begin
    ram_a  = '0;
    ram_di = '0;
    case (state_q)
      ST_RD: begin
        ram_a = src_ptr_s;
      end
      ST_WR: begin
        ram_a  = dst_ptr_s;
        ram_di = (mode_q == MODE_COPY) ? hold_q : fill_q;
      end
      default: begin
        ram_a  = '0;
        ram_di = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_block_mover.sv
// Scoreboard bench for ram_block_mover: a behavioural RAM, a reference
// model that computes the final memory image through a temporary buffer,
// and a monitor that checks every done pulse against the queued expectation.
module tb_ram_block_mover;
  import ram_block_mover_pkg::*;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int DEPTH = 10;
  localparam int VW = DEPTH * DW;

  logic clk = 1'b0;
  logic rst, start, mode;
  logic [AW-1:0] src, dst;
  logic [AW:0] len;
  logic [DW-1:0] fill_val;
  logic busy, done, err, ram_we;
  logic [AW:0] count;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_di, ram_do;

  always #5 clk = ~clk;

  ram_block_mover dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
    .count(count), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
  );

  // behavioural RAM covering the full address space
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  assign ram_do = mem[ram_a];
  always @(posedge clk) if (ram_we) mem[ram_a] <= ram_di;

  typedef struct {
    int lat;
    logic err;
    logic [AW:0] cnt;
    int start_cyc;
    logic [VW-1:0] emem;
  } exp_t;

  exp_t sb[$];
  logic tr_we[$];
  logic [AW-1:0] tr_a[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [VW-1:0] pack_mem();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i*DW +: DW] = mem[i];
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_ref();
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[i*DW +: DW] = ref_mem[i];
    return v;
  endfunction

  // monitor: trace bus activity, pop expectation at every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst == 1'b0) begin
      if (busy) begin
        tr_we.push_back(ram_we);
        tr_a.push_back(ram_a);
      end
      if (ram_we) chk("we_addr_in_range", VW'(ram_a < AW'(DEPTH)), VW'(1));
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", VW'(1), VW'(0));
        end else begin
          e = sb.pop_front();
          chk("err", VW'(err), VW'(e.err));
          chk("count", VW'(count), VW'(e.cnt));
          chk("latency", VW'(cyc + 1 - e.start_cyc), VW'(e.lat));
          chk("mem", pack_mem(), e.emem);
        end
      end
    end
  end

  task automatic set_word(input int i, input logic [DW-1:0] v);
    mem[i] <= v;
    ref_mem[i] = v;
  endtask

  task automatic run_op(input logic m, input int s, input int d, input int l,
                        input logic [DW-1:0] fv, input bit poke);
    exp_t e;
    logic [DW-1:0] tmp [0:DEPTH-1];
    logic ew[$];
    logic [AW-1:0] ea[$];
    bit e_err, desc;
    int d0, waited, idx;
    e_err = (d + l > DEPTH) || (m == MODE_COPY && s + l > DEPTH);
    desc = (m == MODE_COPY) && (d > s);
    if (!e_err) begin
      for (int i = 0; i < DEPTH; i++) tmp[i] = ref_mem[i];
      for (int k = 0; k < l; k++) ref_mem[d + k] = (m == MODE_FILL) ? fv : tmp[s + k];
      for (int k = 0; k < l; k++) begin
        idx = desc ? (l - 1 - k) : k;
        if (m == MODE_COPY) begin
          ew.push_back(1'b0);
          ea.push_back(AW'(s + idx));
        end
        ew.push_back(1'b1);
        ea.push_back(AW'(d + idx));
      end
    end
    e.err = e_err;
    e.cnt = e_err ? '0 : (AW+1)'(l);
    e.lat = (e_err || l == 0) ? 2 : ((m == MODE_FILL) ? 2 + l : 2 + 2 * l);
    e.emem = pack_ref();
    tr_we.delete();
    tr_a.delete();
    d0 = done_cnt;
    mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(l); fill_val = fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.start_cyc = cyc;
    sb.push_back(e);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      chk("busy_during_poke", VW'(busy), VW'(1));
      mode = MODE_FILL; dst = '0; len = 7'd5; fill_val = 16'hDEAD;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    waited = 0;
    while (done_cnt == d0 && waited < 300) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (done_cnt == d0) begin
      chk("done_timeout", VW'(0), VW'(1));
      sb.delete();
    end
    chk("trace_len", VW'(tr_a.size()), VW'(ea.size()));
    for (int i = 0; i < ea.size() && i < tr_a.size(); i++) begin
      chk("trace_we", VW'(tr_we[i]), VW'(ew[i]));
      chk("trace_addr", VW'(tr_a[i]), VW'(ea[i]));
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = MODE_COPY; src = '0; dst = '0;
    len = '0; fill_val = '0;
    for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
    for (int i = 0; i < DEPTH; i++) set_word(i, 16'h1000 + 16'(i));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", VW'(busy), VW'(0));
    chk("rst_done", VW'(done), VW'(0));
    chk("rst_err", VW'(err), VW'(0));
    chk("rst_count", VW'(count), VW'(0));
    chk("rst_we", VW'(ram_we), VW'(0));
    chk("rst_addr", VW'(ram_a), VW'(0));
    chk("rst_di", VW'(ram_di), VW'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases from the plan
    run_op(MODE_FILL, 0, 2, 4, 16'hA5A5, 1'b0);
    set_word(0, 16'd1); set_word(1, 16'd2); set_word(2, 16'd3);
    run_op(MODE_COPY, 0, 5, 3, 16'h0000, 1'b0);
    set_word(1, 16'd11); set_word(2, 16'd22); set_word(3, 16'd33); set_word(4, 16'd44);
    run_op(MODE_COPY, 1, 3, 4, 16'h0000, 1'b0);
    run_op(MODE_FILL, 0, 8, 3, 16'h7777, 1'b0);
    run_op(MODE_COPY, 3, 4, 0, 16'h0000, 1'b0);
    run_op(MODE_COPY, 7, 0, 4, 16'h0000, 1'b0);
    run_op(MODE_COPY, 2, 2, 5, 16'h0000, 1'b0);
    run_op(MODE_FILL, 0, 0, 10, 16'h5A5A, 1'b0);
    run_op(MODE_COPY, 0, 0, 11, 16'h0000, 1'b0);
    for (int i = 0; i < DEPTH; i++) set_word(i, 16'h2000 + 16'(i));
    run_op(MODE_COPY, 0, 4, 5, 16'h0000, 1'b1);

    // reset during the second write of a fill
    mode = MODE_FILL; src = '0; dst = '0; len = 7'd6; fill_val = 16'hBEEF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("we_masked_by_rst", VW'(ram_we), VW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ref_mem[0] = 16'hBEEF;
    chk("abort_busy", VW'(busy), VW'(0));
    chk("abort_count", VW'(count), VW'(0));
    chk("abort_we", VW'(ram_we), VW'(0));
    chk("abort_mem", pack_mem(), pack_ref());
    @(posedge clk); #1;
    run_op(MODE_FILL, 0, 1, 3, 16'hC3C3, 1'b0);

    // randomized operations
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < DEPTH; i++) set_word(i, 16'($urandom));
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 9), $urandom_range(0, 9),
             $urandom_range(0, 10), 16'($urandom), 1'b0);
    end

    chk("sb_empty", VW'(sb.size()), VW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
